uart_instr_server: RTL and testbench

//  Responder end of the bitty UART fetch/load-store link. Sits on the host/test FPGA behind its
//  own uart_module instance and answers the CPU side's requests. Decodes command frames

---
 rtl/uart_instr_server_pkg.sv | 28 ++
 rtl/uart_instr_server_if.sv | 23 ++
 rtl/uart_instr_server_mem.sv | 23 ++
 rtl/uart_instr_server.sv | 134 +++++++++++++
 tb/tb_uart_instr_server.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_instr_server_pkg.sv
// Command codes, reply constants and FSM state encoding shared by the UART fetch/load-store responder.
package bitty_uart_pkg;

  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_FETCH = 8'h03;
  localparam logic [7:0] ACK_BYTE  = 8'hAA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_HI,
    S_GET_LO,
    S_RD,
    S_SEND_HI,
    S_WAIT_HI,
    S_SEND_LO,
    S_WAIT_LO,
    S_WR,
    S_SEND_ACK,
    S_WAIT_ACK
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_READ) || (b == CMD_WRITE) || (b == CMD_FETCH);
  endfunction

endpackage

// File: rtl/uart_instr_server_if.sv
// UART byte link plus host preload port of the responder; master = host/bench side, slave = server.
interface uart_instr_server_if #(parameter int ADDR_W = 8);
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              tx_done;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [15:0]       load_data;
  logic              busy;
  logic              err;

  modport master (
    output rx_done, rx_data, tx_done, load_we, load_addr, load_data,
    input  tx_en, tx_data, busy, err
  );

  modport slave (
    input  rx_done, rx_data, tx_done, load_we, load_addr, load_data,
    output tx_en, tx_data, busy, err
  );
endinterface

// File: rtl/uart_instr_server_mem.sv
// 2**ADDR_W x 16 word memory, one write port and one registered read port; read-first on collision.
module uart_srv_mem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [15:0]       o_rdata
);
  logic [15:0] r_mem [2**ADDR_W];
  logic [15:0] r_rdata;

  // Contents survive reset, so the array and read register have no reset term.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/uart_instr_server.sv
// Decodes fetch/read/write frames from rx bytes and replies on tx; first reply byte 3 cycles after the
// address byte, each following byte waits for tx_done; stray rx bytes during a reply are dropped with err.
module uart_instr_server
  import bitty_uart_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic                clk,
  input logic                reset,
  uart_instr_server_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_cmd, r_hi, r_lo, r_tx_data, w_tx_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [TW-1:0]     r_timer, w_timer_nxt;
  logic              r_tx_en, r_err;
  logic              w_err_nxt, w_tx_fire, w_rd_en, w_wr_en, w_get;
  logic [15:0]       w_imem_rdata, w_dmem_rdata, w_word;

  assign w_get  = (r_state == S_GET_ADDR) || (r_state == S_GET_HI) || (r_state == S_GET_LO);
  assign w_word = (r_cmd == CMD_FETCH) ? w_imem_rdata : w_dmem_rdata;

  uart_srv_mem #(.ADDR_W(ADDR_W)) u_imem (
    .clk(clk), .i_we(bus.load_we), .i_waddr(bus.load_addr), .i_wdata(bus.load_data),
    .i_re(w_rd_en), .i_raddr(r_addr), .o_rdata(w_imem_rdata)
  );

  uart_srv_mem #(.ADDR_W(ADDR_W)) u_dmem (
    .clk(clk), .i_we(w_wr_en), .i_waddr(r_addr), .i_wdata({r_hi, r_lo}),
    .i_re(w_rd_en), .i_raddr(r_addr), .o_rdata(w_dmem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_err_nxt   = 1'b0;
    w_tx_fire   = 1'b0;
    w_tx_byte   = r_tx_data;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (bus.rx_done) begin
          if (is_cmd(bus.rx_data)) w_state_nxt = S_GET_ADDR;
          else                     w_err_nxt   = 1'b1;
        end
      end
      S_GET_ADDR, S_GET_HI, S_GET_LO: begin
        if (bus.rx_done) begin
          w_timer_nxt = '0;
          if (r_state == S_GET_ADDR)    w_state_nxt = (r_cmd == CMD_WRITE) ? S_GET_HI : S_RD;
          else if (r_state == S_GET_HI) w_state_nxt = S_GET_LO;
          else                          w_state_nxt = S_WR;
        end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
          w_timer_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_RD: begin
        w_rd_en     = 1'b1;
        w_state_nxt = S_SEND_HI;
      end
      S_SEND_HI: begin
        w_tx_fire   = 1'b1;
        w_tx_byte   = w_word[15:8];
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: if (bus.tx_done) w_state_nxt = S_SEND_LO;
      S_SEND_LO: begin
        w_tx_fire   = 1'b1;
        w_tx_byte   = w_word[7:0];
        w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: if (bus.tx_done) w_state_nxt = S_IDLE;
      S_WR: begin
        w_wr_en     = 1'b1;
        w_state_nxt = S_SEND_ACK;
      end
      S_SEND_ACK: begin
        w_tx_fire   = 1'b1;
        w_tx_byte   = ACK_BYTE;
        w_state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (bus.tx_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // A byte arriving while a reply is in flight cannot be queued; flag it and carry on.
    if (bus.rx_done && (r_state != S_IDLE) && !w_get) w_err_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd     <= '0;
      r_addr    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_timer   <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_timer   <= w_timer_nxt;
      r_err     <= w_err_nxt;
      r_tx_en   <= w_tx_fire;
      r_tx_data <= w_tx_byte;
      if (bus.rx_done) begin
        case (r_state)
          S_IDLE:     r_cmd  <= bus.rx_data;
          S_GET_ADDR: r_addr <= bus.rx_data[ADDR_W-1:0];
          S_GET_HI:   r_hi   <= bus.rx_data;
          S_GET_LO:   r_lo   <= bus.rx_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.tx_en   = r_tx_en;
  assign bus.tx_data = r_tx_data;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.err     = r_err;
endmodule

// File: tb/tb_uart_instr_server.sv
// Bench for uart_instr_server: directed frames against a memory/reply-queue model, checked every cycle.
module tb_uart_instr_server;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_instr_server_if #(.ADDR_W(8)) bus();
  uart_instr_server #(.ADDR_W(8), .TIMEOUT_CYC(100)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_vec = 0;
  int          n_bad = 0;
  logic [7:0]  exp_q[$];
  int          exp_err = 0;
  logic [15:0] m_imem [256];
  logic [15:0] m_dmem [256];
  logic        hold = 1'b0;
  logic [7:0]  held;
  logic [7:0]  e_byte;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Every byte the DUT launches must be the next one the model owes; it must then hold until tx_done.
  always @(negedge clk) begin
    if (reset) begin
      hold = 1'b0;
    end else begin
      if (bus.tx_en) begin
        chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_byte = exp_q.pop_front();
          chk("tx_byte", 32'(bus.tx_data), 32'(e_byte));
          hold = 1'b1;
          held = e_byte;
        end
      end else if (hold) begin
        chk("tx_hold", 32'(bus.tx_data), 32'(held));
        if (bus.tx_done) hold = 1'b0;
      end
      if (bus.err) begin
        chk("err_expected", 32'(exp_err > 0), 32'd1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk);
    #1 bus.rx_done = 1'b0;
  endtask

  task automatic wait_tx_en(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_en && n < 60);
    if (!bus.tx_en) chk("tx_en_timeout", 32'(n), 32'd0);
  endtask

  task automatic done_pulse(input int gap);
    repeat (gap) @(posedge clk);
    #1 bus.tx_done = 1'b1;
    @(posedge clk);
    #1 bus.tx_done = 1'b0;
  endtask

  task automatic ack_tx(input int gap);
    int n;
    wait_tx_en(n);
    done_pulse(gap);
  endtask

  task automatic check_idle(input string nm);
    @(negedge clk);
    chk(nm, 32'(bus.busy), 32'd0);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk);
    #1 bus.load_we = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    @(posedge clk);
    #1 bus.load_we = 1'b0;
    m_imem[a] = d;
  endtask

  task automatic fetch(input logic [7:0] a);
    exp_q.push_back(m_imem[a][15:8]);
    exp_q.push_back(m_imem[a][7:0]);
    send_byte(8'h03);
    send_byte(a);
    ack_tx(1);
    ack_tx(2);
    check_idle("busy_after_fetch");
  endtask

  task automatic read(input logic [7:0] a);
    exp_q.push_back(m_dmem[a][15:8]);
    exp_q.push_back(m_dmem[a][7:0]);
    send_byte(8'h01);
    send_byte(a);
    ack_tx(1);
    ack_tx(1);
    check_idle("busy_after_read");
  endtask

  task automatic write(input logic [7:0] a, input logic [15:0] w);
    int n;
    m_dmem[a] = w;
    exp_q.push_back(8'hAA);
    send_byte(8'h02);
    send_byte(a);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    wait_tx_en(n);
    chk("lit_ack", 32'(bus.tx_data), 32'h0000_00AA);
    done_pulse(1);
    check_idle("busy_after_write");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    bus.tx_done = 1'b0;
    bus.load_we = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx_en", 32'(bus.tx_en), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    @(posedge clk);
    #2 reset = 1'b0;

    // Fetch with first-byte latency and literal reply bytes.
    preload(8'h05, 16'h1234);
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_byte(8'h03);
    send_byte(8'h05);
    wait_tx_en(n);
    chk("fetch_latency", 32'(n), 32'd3);
    chk("lit_hi", 32'(bus.tx_data), 32'h12);
    chk("busy_during", 32'(bus.busy), 32'd1);
    done_pulse(1);
    wait_tx_en(n);
    chk("lit_lo", 32'(bus.tx_data), 32'h34);
    done_pulse(3);
    check_idle("busy_after_first");

    // Write then read back.
    write(8'h10, 16'hBEEF);
    read(8'h10);

    // Unknown command.
    exp_err++;
    send_byte(8'h07);
    @(negedge clk);
    chk("badcmd_err", 32'(bus.err), 32'd1);
    chk("badcmd_tx_en", 32'(bus.tx_en), 32'd0);
    chk("badcmd_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("badcmd_err_1cyc", 32'(bus.err), 32'd0);
    chk("badcmd_busy2", 32'(bus.busy), 32'd0);

    // Partial write frame abandoned: timeout, no dmem update.
    exp_err++;
    send_byte(8'h02);
    send_byte(8'h10);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!bus.err && n < 200);
    chk("timeout_cycle", 32'(n), 32'd100);
    chk("timeout_busy", 32'(bus.busy), 32'd0);
    read(8'h10);

    // Stray byte during WAIT_HI.
    exp_q.push_back(m_imem[8'h05][15:8]);
    exp_q.push_back(m_imem[8'h05][7:0]);
    send_byte(8'h03);
    send_byte(8'h05);
    wait_tx_en(n);
    exp_err++;
    send_byte(8'h55);
    done_pulse(1);
    ack_tx(1);
    check_idle("busy_after_stray");
    fetch(8'h05);

    // Preload write landing on the read cycle returns the old word.
    preload(8'h20, 16'h5A5A);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    send_byte(8'h03);
    send_byte(8'h20);
    bus.load_we = 1'b1;
    bus.load_addr = 8'h20;
    bus.load_data = 16'hC3C3;
    @(posedge clk);
    #1 bus.load_we = 1'b0;
    m_imem[8'h20] = 16'hC3C3;
    ack_tx(1);
    ack_tx(1);
    check_idle("busy_after_rf");
    fetch(8'h20);

    // Reset while the low byte is being sent.
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_byte(8'h03);
    send_byte(8'h05);
    ack_tx(1);
    wait_tx_en(n);
    #1 reset = 1'b1;
    #1;
    chk("arst_tx_en", 32'(bus.tx_en), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_tx_data", 32'(bus.tx_data), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    fetch(8'h05);

    repeat (3) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("err_all_seen", 32'(exp_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
